// File: rtl/channel_scan_sequencer.sv
// Round-robin ADC scan controller: walks the enabled channels over a req/ack
// handshake, forwards samples, and runs post-trigger capture plus holdoff.
module channel_scan_sequencer #(
  parameter int NUM_CHANNELS  = 16,
  parameter int ADC_WIDTH     = 12,
  parameter int CHANNEL_WIDTH = $clog2(NUM_CHANNELS),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_CHANNELS-1:0]  channel_mask,
  input  logic [CNT_WIDTH-1:0]     post_trigger_samples,
  input  logic [CNT_WIDTH-1:0]     holdoff_cycles,
  output logic                     adc_req,
  output logic [CHANNEL_WIDTH-1:0] adc_channel,
  input  logic                     adc_ack,
  input  logic [ADC_WIDTH-1:0]     adc_data,
  output logic [ADC_WIDTH-1:0]     data_out,
  output logic [CHANNEL_WIDTH-1:0] channel_out,
  output logic                     data_valid_out,
  input  logic                     trigger_in,
  output logic                     busy,
  output logic                     triggered,
  output logic                     capture_done,
  output logic                     cfg_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EMIT, S_HOLDOFF} state_e;

  state_e                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_CHANNELS-1:0]  mask_q, mask_d;
  logic [CNT_WIDTH-1:0]     post_cfg_q, post_cfg_d;
  logic [CNT_WIDTH-1:0]     hold_cfg_q, hold_cfg_d;
  logic [CNT_WIDTH-1:0]     post_cnt_q, post_cnt_d;
  logic [CNT_WIDTH-1:0]     hold_cnt_q, hold_cnt_d;
  logic                     post_phase_q, post_phase_d;
  logic                     triggered_q, triggered_d;
  logic                     stop_pend_q, stop_pend_d;
  logic [ADC_WIDTH-1:0]     data_out_q, data_out_d;
  logic [CHANNEL_WIDTH-1:0] channel_out_q, channel_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     capture_done_q, capture_done_d;
  logic                     cfg_error_q, cfg_error_d;

  logic                     trig_acc;
  logic                     stop_eff;
  logic                     phase_eff;
  logic [CNT_WIDTH-1:0]     cnt_eff;

  function automatic logic [CHANNEL_WIDTH-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CHANNELS-1; i >= 0; i--)
      if (m[i]) lowest_set = CHANNEL_WIDTH'(i);
  endfunction

  // Next enabled channel strictly above cur, wrapping to the lowest one.
  function automatic logic [CHANNEL_WIDTH-1:0] next_set(input logic [NUM_CHANNELS-1:0] m,
                                                        input logic [CHANNEL_WIDTH-1:0] cur);
    logic found;
    next_set = lowest_set(m);
    found    = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (!found && m[i] && (i > int'(cur))) begin
        next_set = CHANNEL_WIDTH'(i);
        found    = 1'b1;
      end
  endfunction

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    mask_d         = mask_q;
    post_cfg_d     = post_cfg_q;
    hold_cfg_d     = hold_cfg_q;
    post_cnt_d     = post_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    post_phase_d   = post_phase_q;
    triggered_d    = triggered_q;
    stop_pend_d    = stop_pend_q;
    data_out_d     = data_out_q;
    channel_out_d  = channel_out_q;
    data_valid_d   = 1'b0;
    capture_done_d = 1'b0;
    cfg_error_d    = 1'b0;

    trig_acc  = trigger_in && !post_phase_q && (state_q == S_REQ || state_q == S_EMIT);
    stop_eff  = stop_pend_q || stop;
    phase_eff = post_phase_q || trig_acc;
    cnt_eff   = trig_acc ? post_cfg_q : post_cnt_q;

    if (trig_acc) begin
      post_phase_d = 1'b1;
      triggered_d  = 1'b1;
      post_cnt_d   = post_cfg_q;
    end
    if (stop && state_q != S_IDLE) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (|channel_mask) begin
            mask_d     = channel_mask;
            post_cfg_d = post_trigger_samples;
            hold_cfg_d = holdoff_cycles;
            ptr_d      = lowest_set(channel_mask);
            state_d    = S_REQ;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (adc_ack) begin
          data_out_d    = adc_data;
          channel_out_d = ptr_q;
          data_valid_d  = 1'b1;
          ptr_d         = next_set(mask_q, ptr_q);
          state_d       = S_EMIT;
          // A zero count at ack only happens with post_trigger_samples=0:
          // skip the emit gap and go straight to holdoff.
          if (phase_eff) begin
            if (cnt_eff == '0) begin
              if (!stop_eff) state_d = S_HOLDOFF;
            end else begin
              post_cnt_d = cnt_eff - CNT_WIDTH'(1);
            end
          end
        end
      end
      S_EMIT: begin
        if (stop_eff)                         state_d = S_IDLE;
        else if (phase_eff && cnt_eff == '0) state_d = S_HOLDOFF;
        else                                  state_d = S_REQ;
      end
      S_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          post_phase_d = 1'b0;
          triggered_d  = 1'b0;
          state_d      = stop_eff ? S_IDLE : S_REQ;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_HOLDOFF && state_q != S_HOLDOFF) begin
      hold_cnt_d     = hold_cfg_q;
      capture_done_d = 1'b1;
    end
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      stop_pend_d  = 1'b0;
      post_phase_d = 1'b0;
      triggered_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      mask_q         <= '0;
      post_cfg_q     <= '0;
      hold_cfg_q     <= '0;
      post_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      post_phase_q   <= 1'b0;
      triggered_q    <= 1'b0;
      stop_pend_q    <= 1'b0;
      data_out_q     <= '0;
      channel_out_q  <= '0;
      data_valid_q   <= 1'b0;
      capture_done_q <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      mask_q         <= mask_d;
      post_cfg_q     <= post_cfg_d;
      hold_cfg_q     <= hold_cfg_d;
      post_cnt_q     <= post_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      post_phase_q   <= post_phase_d;
      triggered_q    <= triggered_d;
      stop_pend_q    <= stop_pend_d;
      data_out_q     <= data_out_d;
      channel_out_q  <= channel_out_d;
      data_valid_q   <= data_valid_d;
      capture_done_q <= capture_done_d;
      cfg_error_q    <= cfg_error_d;
    end
  end

  assign adc_req        = (state_q == S_REQ);
  assign adc_channel    = ptr_q;
  assign busy           = (state_q != S_IDLE);
  assign triggered      = triggered_q;
  assign data_out       = data_out_q;
  assign channel_out    = channel_out_q;
  assign data_valid_out = data_valid_q;
  assign capture_done   = capture_done_q;
  assign cfg_error      = cfg_error_q;

endmodule
